// File: rtl/delay_mc_if.sv
// Frame-level interface of the multichannel delay: coefficients, audio in/out and status.
// The slave modport is the delay core; the master modport is whatever feeds and consumes it.
interface delay_mc_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned NUM_CH     = 2
);
    logic [ADDR_WIDTH-1:0]        i_delay;
    logic [DATA_WIDTH-1:0]        i_feedback;
    logic [DATA_WIDTH-1:0]        i_wet;
    logic [DATA_WIDTH-1:0]        i_dry;
    logic                         i_pingpong;
    logic [NUM_CH*DATA_WIDTH-1:0] i_audio;
    logic                         i_audio_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] o_audio;
    logic                         o_audio_valid;
    logic                         o_busy;
    logic                         o_overrun;

    modport master (
        output i_delay, i_feedback, i_wet, i_dry, i_pingpong, i_audio, i_audio_valid,
        input  o_audio, o_audio_valid, o_busy, o_overrun
    );

    modport slave (
        input  i_delay, i_feedback, i_wet, i_dry, i_pingpong, i_audio, i_audio_valid,
        output o_audio, o_audio_valid, o_busy, o_overrun
    );
endinterface

// File: rtl/delay_mc.sv
// Multichannel feedback delay with wet/dry mix and optional ping-pong cross-feedback.
// Channels share one simple dual-port RAM and one multiplier set, processed one at a time.
module delay_mc #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned COEF_FRAC  = 14
) (
    input logic       i_clk,
    input logic       i_reset_n,
    delay_mc_if.slave bus
);

    localparam int unsigned DW        = DATA_WIDTH;
    localparam int unsigned PW        = 2 * DATA_WIDTH;
    localparam int unsigned FW        = NUM_CH * DATA_WIDTH;
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned MEM_DEPTH = NUM_CH << ADDR_WIDTH;
    localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);

    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW - 1){1'b0}}};
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW - 1){1'b1}}};

    localparam logic [2:0] StClear = 3'd0;
    localparam logic [2:0] StIdle  = 3'd1;
    localparam logic [2:0] StRd    = 3'd2;
    localparam logic [2:0] StRdw   = 3'd3;
    localparam logic [2:0] StMul   = 3'd4;
    localparam logic [2:0] StWr    = 3'd5;
    localparam logic [2:0] StOut   = 3'd6;

    // Q-format product back to sample scale: floor shift, then clamp to sample range.
    function automatic logic [DW-1:0] scale(input logic [PW-1:0] p);
        logic [PW-1:0] s;
        s = $signed(p) >>> COEF_FRAC;
        if ((&s[PW-1:DW-1]) || (~|s[PW-1:DW-1])) return s[DW-1:0];
        return s[PW-1] ? SAT_MIN : SAT_MAX;
    endfunction

    function automatic logic [DW-1:0] sat_sum(input logic [DW:0] s);
        if (s[DW] == s[DW-1]) return s[DW-1:0];
        return s[DW] ? SAT_MIN : SAT_MAX;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [MEM_AW-1:0]     clr_q, clr_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] dly_q, dly_d;
    logic signed [DW-1:0]  fb_q, fb_d;
    logic signed [DW-1:0]  wet_q, wet_d;
    logic signed [DW-1:0]  dry_q, dry_d;
    logic                  pp_q, pp_d;
    logic [FW-1:0]         x_q, x_d;
    logic [FW-1:0]         delayed_q, delayed_d;
    logic [FW-1:0]         stage_q, stage_d;
    logic [PW-1:0]         p_fb_q, p_fb_d;
    logic [PW-1:0]         p_wet_q, p_wet_d;
    logic [PW-1:0]         p_dry_q, p_dry_d;
    logic [FW-1:0]         audio_q, audio_d;
    logic                  audio_valid_q, audio_valid_d;
    logic                  overrun_q, overrun_d;

    logic [DW-1:0]         mem [MEM_DEPTH];
    logic [DW-1:0]         rdata_q;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_waddr;
    logic [MEM_AW-1:0]     mem_raddr;
    logic [DW-1:0]         mem_wdata;

    logic                  busy;
    logic                  last_ch;
    logic [CH_W-1:0]       src_ch;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic signed [DW-1:0]  x_c;
    logic signed [DW-1:0]  delayed_c;
    logic signed [DW-1:0]  delayed_src;
    logic [DW-1:0]         fb_s, wet_s, dry_s;
    logic [DW:0]           wr_sum, out_sum;

    assign busy    = (state_q != StIdle);
    assign last_ch = (ch_q == CH_W'(NUM_CH - 1));
    assign rd_ptr  = w_ptr_q - dly_q;

    // Ping-pong feeds channel c from its neighbour c+1, wrapping to channel 0.
    always_comb begin
        src_ch = ch_q;
        if (pp_q) src_ch = last_ch ? '0 : ch_q + CH_W'(1);
    end

    assign x_c         = x_q[32'(ch_q) * DW +: DW];
    assign delayed_c   = delayed_q[32'(ch_q) * DW +: DW];
    assign delayed_src = delayed_q[32'(src_ch) * DW +: DW];

    assign fb_s    = scale(p_fb_q);
    assign wet_s   = scale(p_wet_q);
    assign dry_s   = scale(p_dry_q);
    assign wr_sum  = {x_c[DW-1], x_c} + {fb_s[DW-1], fb_s};
    assign out_sum = {dry_s[DW-1], dry_s} + {wet_s[DW-1], wet_s};

    assign mem_raddr = MEM_AW'({ch_q, rd_ptr});

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_q;
        mem_wdata = '0;
        if (state_q == StClear) begin
            mem_we = 1'b1;
        end else if (state_q == StWr) begin
            mem_we    = 1'b1;
            mem_waddr = MEM_AW'({ch_q, w_ptr_q});
            mem_wdata = sat_sum(wr_sum);
        end
    end

    always_comb begin
        state_d       = state_q;
        clr_d         = clr_q;
        ch_d          = ch_q;
        w_ptr_d       = w_ptr_q;
        dly_d         = dly_q;
        fb_d          = fb_q;
        wet_d         = wet_q;
        dry_d         = dry_q;
        pp_d          = pp_q;
        x_d           = x_q;
        delayed_d     = delayed_q;
        stage_d       = stage_q;
        p_fb_d        = p_fb_q;
        p_wet_d       = p_wet_q;
        p_dry_d       = p_dry_q;
        audio_d       = audio_q;
        audio_valid_d = 1'b0;
        overrun_d     = bus.i_audio_valid && busy;

        case (state_q)
            StClear: begin
                clr_d = clr_q + MEM_AW'(1);
                if (clr_q == MEM_AW'(MEM_DEPTH - 1)) begin
                    clr_d   = '0;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (bus.i_audio_valid) begin
                    x_d     = bus.i_audio;
                    dly_d   = (bus.i_delay == '0) ? ADDR_WIDTH'(1) : bus.i_delay;
                    fb_d    = bus.i_feedback;
                    wet_d   = bus.i_wet;
                    dry_d   = bus.i_dry;
                    pp_d    = bus.i_pingpong;
                    ch_d    = '0;
                    state_d = StRd;
                end
            end
            StRd: begin
                // Read data lags the address by one cycle, so this captures channel ch-1.
                if (ch_q != '0) delayed_d[32'(ch_q - CH_W'(1)) * DW +: DW] = rdata_q;
                ch_d = ch_q + CH_W'(1);
                if (last_ch) begin
                    ch_d    = '0;
                    state_d = StRdw;
                end
            end
            StRdw: begin
                delayed_d[(NUM_CH - 1) * DW +: DW] = rdata_q;
                state_d = StMul;
            end
            StMul: begin
                p_fb_d  = PW'(delayed_src) * PW'(fb_q);
                p_wet_d = PW'(delayed_c) * PW'(wet_q);
                p_dry_d = PW'(x_c) * PW'(dry_q);
                state_d = StWr;
            end
            StWr: begin
                stage_d[32'(ch_q) * DW +: DW] = sat_sum(out_sum);
                if (last_ch) begin
                    ch_d    = '0;
                    state_d = StOut;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = StMul;
                end
            end
            StOut: begin
                audio_d       = stage_q;
                audio_valid_d = 1'b1;
                w_ptr_d       = w_ptr_q + ADDR_WIDTH'(1);
                state_d       = StIdle;
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= StClear;
            clr_q         <= '0;
            ch_q          <= '0;
            w_ptr_q       <= '0;
            dly_q         <= ADDR_WIDTH'(1);
            fb_q          <= '0;
            wet_q         <= '0;
            dry_q         <= '0;
            pp_q          <= 1'b0;
            x_q           <= '0;
            delayed_q     <= '0;
            stage_q       <= '0;
            p_fb_q        <= '0;
            p_wet_q       <= '0;
            p_dry_q       <= '0;
            audio_q       <= '0;
            audio_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_q         <= clr_d;
            ch_q          <= ch_d;
            w_ptr_q       <= w_ptr_d;
            dly_q         <= dly_d;
            fb_q          <= fb_d;
            wet_q         <= wet_d;
            dry_q         <= dry_d;
            pp_q          <= pp_d;
            x_q           <= x_d;
            delayed_q     <= delayed_d;
            stage_q       <= stage_d;
            p_fb_q        <= p_fb_d;
            p_wet_q       <= p_wet_d;
            p_dry_q       <= p_dry_d;
            audio_q       <= audio_d;
            audio_valid_q <= audio_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // Block RAM: no reset on the array or the read register.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rdata_q <= mem[mem_raddr];
    end

    assign bus.o_audio       = audio_q;
    assign bus.o_audio_valid = audio_valid_q;
    assign bus.o_busy        = busy;
    assign bus.o_overrun     = overrun_q;

endmodule

// File: tb/tb_delay_mc.sv
// Scoreboard bench for delay_mc: stimulus pushes expected frames, a monitor pops and compares
// them whenever o_audio_valid is seen.
module tb_delay_mc;
    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int NCH = 2;
    localparam int CF  = 14;

    typedef struct {
        int          tid;
        int          fi;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ovr_seen = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    delay_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH)) bus ();

    delay_mc #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_CH    (NCH),
        .COEF_FRAC (CF)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every presented frame against the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL t%0d f%0d missing: no o_audio_valid by cycle %0d", e.tid, e.fi, e.due);
        end
        if (bus.o_audio_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected output: got 0x%08h at cycle %0d, expected none",
                         bus.o_audio, cyc);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("t%0d f%0d latency", e.tid, e.fi), 32'(cyc), 32'(e.due));
                check($sformatf("t%0d f%0d audio", e.tid, e.fi), bus.o_audio, e.data);
            end
        end
        if (bus.o_overrun) ovr_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input int dry, input int wet, input int fb, input int dly,
                           input int pp);
        bus.i_dry      = 16'(dry);
        bus.i_wet      = 16'(wet);
        bus.i_feedback = 16'(fb);
        bus.i_delay    = 4'(dly);
        bus.i_pingpong = 1'(pp);
    endtask

    // Returns the number of edges until o_busy drops (bounded).
    task automatic reset_and_clear(output int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.o_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic send_frame(input int tid, input int fi, input int a0, input int a1,
                              input int e0, input int e1);
        exp_t e;
        @(negedge clk);
        bus.i_audio       = {16'(a1), 16'(a0)};
        bus.i_audio_valid = 1'b1;
        @(posedge clk);
        #1;
        e.tid  = tid;
        e.fi   = fi;
        e.data = {16'(e1), 16'(e0)};
        e.due  = cyc + 8;
        exp_q.push_back(e);
        @(negedge clk);
        bus.i_audio_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        exp_t e;
        bus.i_audio       = '0;
        bus.i_audio_valid = 1'b0;
        set_cfg(0, 0, 0, 1, 0);

        // Test 1: reset values, clear length, strobe dropped during clear.
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.o_busy), 32'd1);
        check("reset audio", bus.o_audio, 32'd0);
        check("reset valid", 32'(bus.o_audio_valid), 32'd0);
        check("reset overrun", 32'(bus.o_overrun), 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (bus.o_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            bus.i_audio       = 32'h0000_1111;
            bus.i_audio_valid = (n == 10);
            if (n == 11) check("clear overrun", 32'(bus.o_overrun), 32'd1);
        end
        bus.i_audio_valid = 1'b0;
        check("clear cycles", 32'(n), 32'd32);
        check("after clear audio", bus.o_audio, 32'd0);

        // Test 2: impulse through a 3-frame delay.
        reset_and_clear(n);
        set_cfg(16384, 16384, 0, 3, 0);
        for (int f = 0; f < 7; f++)
            send_frame(2, f, (f == 0) ? 1000 : 0, 0, (f == 0 || f == 3) ? 1000 : 0, 0);

        // Test 3: feedback halves each repeat.
        reset_and_clear(n);
        set_cfg(0, 16384, 8192, 2, 0);
        for (int f = 0; f < 7; f++)
            send_frame(3, f, (f == 0) ? 8000 : 0, 0,
                       (f == 2) ? 8000 : (f == 4) ? 4000 : (f == 6) ? 2000 : 0, 0);

        // Test 4: ping-pong alternates channels.
        reset_and_clear(n);
        set_cfg(0, 16384, 8192, 2, 1);
        for (int f = 0; f < 7; f++)
            send_frame(4, f, (f == 0) ? 8000 : 0, 0,
                       (f == 2) ? 8000 : (f == 6) ? 2000 : 0, (f == 4) ? 4000 : 0);

        // Test 5: output and stored-value saturation; frame 3 reads the stored values back.
        reset_and_clear(n);
        set_cfg(16384, 16384, 16384, 1, 0);
        send_frame(5, 0, 30000, -30000, 30000, -30000);
        send_frame(5, 1, 30000, -30000, 32767, -32768);
        send_frame(5, 2, 30000, -30000, 32767, -32768);
        set_cfg(0, 16384, 0, 1, 0);
        send_frame(5, 3, 0, 0, 32767, -32768);

        // Test 6a: second strobe 3 cycles after the first is dropped, coefficients unaffected.
        reset_and_clear(n);
        set_cfg(16384, 0, 0, 1, 0);
        @(negedge clk);
        bus.i_audio       = {16'd0, 16'd1234};
        bus.i_audio_valid = 1'b1;
        @(posedge clk);
        #1;
        e.tid  = 6;
        e.fi   = 0;
        e.data = {16'd0, 16'd1234};
        e.due  = cyc + 8;
        exp_q.push_back(e);
        @(negedge clk);
        bus.i_audio_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_audio       = {16'd0, 16'd999};
        bus.i_audio_valid = 1'b1;
        bus.i_dry         = 16'd0;
        @(posedge clk);
        #1;
        check("t6 overrun pulse", 32'(bus.o_overrun), 32'd1);
        @(negedge clk);
        bus.i_audio_valid = 1'b0;
        bus.i_dry         = 16'd16384;
        repeat (12) @(negedge clk);

        // Test 6b: reset in cycle 4 of a frame aborts it and re-clears.
        bus.i_audio       = {16'd0, 16'd555};
        bus.i_audio_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_audio_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6 reset audio", bus.o_audio, 32'd0);
        check("t6 reset valid", 32'(bus.o_audio_valid), 32'd0);
        check("t6 reset busy", 32'(bus.o_busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.o_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6 reclear cycles", 32'(n), 32'd32);
        repeat (20) @(negedge clk);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        check("overrun count", 32'(ovr_seen), 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
